// File: rtl/tick_timer.sv
// Tick-driven down-counter with IDLE/RUN/HOLD control, optional auto-reload and an expiry pulse.
// All outputs are registered. EXPIRE rises the cycle after the tick that reaches zero. There is no backpressure.
module tick_timer #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             TICK,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  input  logic             START,
  input  logic             STOP,
  input  logic             AUTO_RELOAD,
  output logic [WIDTH-1:0] COUNT,
  output logic             RUNNING,
  output logic             EXPIRE,
  output logic [3:0]       EXP_CNT
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             running_q, running_d;
  logic             expire_q, expire_d;
  logic [3:0]       exp_cnt_q, exp_cnt_d;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expire_d  = 1'b0;
    exp_cnt_d = exp_cnt_q;

    if (LOAD) begin
      reload_d  = LOAD_VAL;
      count_d   = LOAD_VAL;
      state_d   = ST_IDLE;
      exp_cnt_d = 4'd0;
    end else if (STOP) begin
      // STOP wins over a simultaneous START in every state.
      if (state_q == ST_RUN) begin
        state_d = ST_HOLD;
      end
    end else begin
      if (START && (state_q == ST_HOLD)) begin
        state_d = ST_RUN;
      end else if (START && (state_q == ST_IDLE) && (count_q != CNT_ZERO)) begin
        state_d = ST_RUN;
      end

      // Only a state register already in RUN counts ticks, so a START cycle never does.
      if (TICK && (state_q == ST_RUN)) begin
        if (count_q > CNT_ONE) begin
          count_d = count_q - CNT_ONE;
        end else if (count_q == CNT_ONE) begin
          expire_d = 1'b1;
          if (exp_cnt_q != 4'hF) begin
            exp_cnt_d = exp_cnt_q + 4'd1;
          end
          if (AUTO_RELOAD && (reload_q != CNT_ZERO)) begin
            count_d = reload_q;
          end else begin
            count_d = CNT_ZERO;
            state_d = ST_IDLE;
          end
        end
      end
    end

    running_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      expire_q  <= 1'b0;
      exp_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      expire_q  <= expire_d;
      exp_cnt_q <= exp_cnt_d;
    end
  end

  assign COUNT   = count_q;
  assign RUNNING = running_q;
  assign EXPIRE  = expire_q;
  assign EXP_CNT = exp_cnt_q;

endmodule

// File: tb/tb_tick_timer.sv
// Directed and randomized checks of tick_timer against a small behavioural reference model.
module tb_tick_timer;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       TICK = 1'b0;
  logic       LOAD = 1'b0;
  logic [7:0] LOAD_VAL = 8'd0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       AUTO_RELOAD = 1'b0;
  logic [7:0] COUNT;
  logic       RUNNING;
  logic       EXPIRE;
  logic [3:0] EXP_CNT;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  // Reference model: the timer is "running", "paused" or neither.
  int m_count = 0;
  int m_reload = 0;
  int m_exp = 0;
  bit m_running = 0;
  bit m_paused = 0;
  bit m_expire = 0;

  tick_timer #(.WIDTH(8)) dut (
    .CLK(CLK), .RESET(RESET), .TICK(TICK), .LOAD(LOAD), .LOAD_VAL(LOAD_VAL),
    .START(START), .STOP(STOP), .AUTO_RELOAD(AUTO_RELOAD),
    .COUNT(COUNT), .RUNNING(RUNNING), .EXPIRE(EXPIRE), .EXP_CNT(EXP_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    if (RESET) begin
      m_count = 0; m_reload = 0; m_exp = 0;
      m_running = 0; m_paused = 0; m_expire = 0;
    end else if (LOAD) begin
      m_count = LOAD_VAL; m_reload = LOAD_VAL; m_exp = 0;
      m_running = 0; m_paused = 0; m_expire = 0;
    end else begin
      m_expire = 0;
      if (STOP) begin
        if (m_running) begin
          m_running = 0; m_paused = 1;
        end
      end else if (START && !m_running) begin
        if (m_paused || m_count != 0) begin
          m_running = 1; m_paused = 0;
        end
      end else if (TICK && m_running) begin
        m_count = m_count - 1;
        if (m_count == 0) begin
          m_expire = 1;
          m_exp = (m_exp >= 15) ? 15 : m_exp + 1;
          if (AUTO_RELOAD && m_reload != 0) m_count = m_reload;
          else m_running = 0;
        end
      end
    end
  endtask

  // One clock: inputs are already set, the model advances at the edge, outputs are checked 1ns later.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    chk("count", COUNT, m_count);
    chk("running", RUNNING, m_running);
    chk("expire", EXPIRE, m_expire);
    chk("exp_cnt", EXP_CNT, m_exp);
    if (EXPIRE === 1'b1) pulses++;
  endtask

  task automatic set_in(input bit t, input bit l, input bit st, input bit sp);
    TICK = t; LOAD = l; START = st; STOP = sp;
  endtask

  initial begin
    // Reset state.
    RESET = 1'b1;
    set_in(0, 0, 0, 0);
    step();
    chk("rst_count", COUNT, 0);
    chk("rst_running", RUNNING, 0);
    RESET = 1'b0;

    // One-shot from 3 with a tick every second cycle.
    LOAD_VAL = 8'd3; AUTO_RELOAD = 1'b0;
    set_in(0, 1, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    chk("oneshot_run", RUNNING, 1);
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 0); step();
      set_in(1, 0, 0, 0); step();
      chk("oneshot_cnt", COUNT, 2 - i);
    end
    set_in(0, 0, 0, 0); step();
    chk("oneshot_pulses", pulses, 1);
    chk("oneshot_idle", RUNNING, 0);
    chk("oneshot_expcnt", EXP_CNT, 1);

    // Auto-reload from 2 with 40 back-to-back ticks.
    LOAD_VAL = 8'd2; AUTO_RELOAD = 1'b1;
    set_in(0, 1, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      set_in(1, 0, 0, 0); step();
      chk("auto_cnt", COUNT, (i % 2 == 0) ? 1 : 2);
      chk("auto_run", RUNNING, 1);
      if (i == 29) chk("auto_sat15", EXP_CNT, 15);
    end
    set_in(0, 0, 0, 0); step();
    chk("auto_pulses", pulses, 20);
    chk("auto_expcnt", EXP_CNT, 15);

    // Pause and resume from 5.
    LOAD_VAL = 8'd5; AUTO_RELOAD = 1'b0;
    set_in(0, 1, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    pulses = 0;
    repeat (2) begin set_in(1, 0, 0, 0); step(); end
    set_in(0, 0, 0, 1); step();
    repeat (4) begin set_in(1, 0, 0, 0); step(); chk("hold_cnt", COUNT, 3); end
    // START together with STOP while paused stays paused.
    set_in(0, 0, 1, 1); step();
    chk("hold_startstop", RUNNING, 0);
    set_in(1, 0, 1, 0); step();
    chk("resume_cnt", COUNT, 3);
    repeat (3) begin set_in(1, 0, 0, 0); step(); end
    set_in(0, 0, 0, 0); step();
    chk("resume_zero", COUNT, 0);
    chk("resume_pulses", pulses, 1);

    // START with TICK from IDLE at 4: the tick is not counted.
    LOAD_VAL = 8'd4;
    set_in(0, 1, 0, 0); step();
    set_in(1, 0, 1, 0); step();
    chk("start_tick_cnt", COUNT, 4);

    // LOAD wins over an expiring tick.
    LOAD_VAL = 8'd2;
    set_in(0, 1, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    set_in(1, 0, 0, 0); step();
    chk("pre_load_cnt", COUNT, 1);
    LOAD_VAL = 8'd7;
    set_in(1, 1, 0, 0); step();
    chk("load_cnt", COUNT, 7);
    chk("load_idle", RUNNING, 0);
    set_in(0, 0, 0, 0); step();
    chk("load_noexp", EXPIRE, 0);
    chk("load_expcnt", EXP_CNT, 0);

    // RESET discards an expiring tick.
    LOAD_VAL = 8'd1;
    set_in(0, 1, 0, 0); step();
    set_in(0, 0, 1, 0); step();
    RESET = 1'b1;
    set_in(1, 0, 0, 0); step();
    RESET = 1'b0;
    chk("rst_mid_cnt", COUNT, 0);
    chk("rst_mid_expire", EXPIRE, 0);
    set_in(0, 0, 0, 0); step();
    chk("rst_mid_noexp", EXPIRE, 0);
    set_in(0, 0, 1, 0); step();
    chk("rst_start_ign", RUNNING, 0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      RESET = ($urandom_range(99) < 2);
      LOAD = ($urandom_range(99) < 6);
      START = ($urandom_range(99) < 20);
      STOP = ($urandom_range(99) < 6);
      TICK = ($urandom_range(99) < 60);
      if ($urandom_range(99) < 10) AUTO_RELOAD = $urandom_range(1);
      LOAD_VAL = ($urandom_range(3) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(4));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL expose parameter WIDTH, default 8, setting the counter and load-value width.
REQ-003 The block SHALL have port CLK, input, 1, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port TICK, input, 1, one-cycle count-enable pulse from the clock generator's INT_CLK.
REQ-006 The block SHALL have port LOAD, input, 1, load strobe.
REQ-007 The block SHALL have port LOAD_VAL, input, WIDTH, initial and reload value.
REQ-008 The block SHALL have port START, input, 1, start/resume strobe.
REQ-009 The block SHALL have port STOP, input, 1, pause strobe.
REQ-010 The block SHALL have port AUTO_RELOAD, input, 1, reload on expiry when 1.
REQ-011 The block SHALL have port COUNT, output, WIDTH, current count value.
REQ-012 The block SHALL have port RUNNING, output, 1, high while in state RUN.
REQ-013 The block SHALL have port EXPIRE, output, 1, registered one-cycle expiry pulse.
REQ-014 The block SHALL have port EXP_CNT, output, 4, saturating expiry counter.

Function
REQ-015 The block SHALL implement states IDLE, RUN and HOLD; RUNNING SHALL be 1 only in RUN.
REQ-016 The block SHALL hold an internal WIDTH-bit RELOAD register.
REQ-017 Input priority per cycle SHALL be LOAD > STOP > START > TICK.
REQ-018 LOAD in any state SHALL set RELOAD and COUNT to LOAD_VAL, enter IDLE, clear EXP_CNT to 0, ignore any TICK that cycle, and suppress EXPIRE the following cycle.
REQ-019 START in IDLE with COUNT != 0 SHALL enter RUN; START in IDLE with COUNT == 0 SHALL be ignored.
REQ-020 START in HOLD SHALL enter RUN; START in RUN SHALL have no effect.
REQ-021 STOP in RUN SHALL enter HOLD with COUNT frozen; STOP in IDLE or HOLD SHALL have no effect.
REQ-022 STOP and START asserted in the same cycle SHALL resolve as STOP alone.
REQ-023 A TICK SHALL be counted only when the state register already equals RUN; a TICK in the cycle START is applied SHALL NOT be counted.
REQ-024 A counted TICK with COUNT > 1 SHALL decrement COUNT by 1.
REQ-025 A counted TICK with COUNT == 1 SHALL be an expiry event.
REQ-026 On expiry with AUTO_RELOAD = 1 and RELOAD != 0, COUNT SHALL load RELOAD and the state SHALL remain RUN.
REQ-027 On expiry otherwise, COUNT SHALL become 0 and the state SHALL become IDLE.
REQ-028 EXPIRE SHALL be 1 for exactly the one cycle after each expiry event.
REQ-029 Each expiry event SHALL increment EXP_CNT by 1, saturating at 15 with no wrap.
REQ-030 TICK in consecutive cycles SHALL be legal, with each tick counted.
REQ-031 COUNT SHALL never wrap below 0.

Reset
REQ-032 RESET = 1 SHALL override all other inputs.
REQ-033 At the next rising CLK edge with RESET = 1, the block SHALL set state IDLE, COUNT 0, RELOAD 0, RUNNING 0, EXPIRE 0 and EXP_CNT 0.
REQ-034 RESET asserted mid-operation SHALL discard any pending expiry, and no EXPIRE pulse SHALL follow it.

Verification
REQ-035 Test: RESET, then LOAD_VAL=3 with LOAD, START, TICK every 2nd cycle -> COUNT 3,2,1,0; EXPIRE high one cycle after the 3rd counted tick; RUNNING falls to 0; EXP_CNT=1.
REQ-036 Test: LOAD_VAL=2, AUTO_RELOAD=1, START, 40 ticks -> COUNT cycles 2,1,2,1,...; 20 EXPIRE pulses; EXP_CNT holds 15 after the 15th expiry; RUNNING stays 1.
REQ-037 Test: LOAD_VAL=5, START, 2 ticks, STOP, 4 ticks, START, 3 ticks -> COUNT holds 3 during HOLD, then 0; exactly 1 EXPIRE.
REQ-038 Test: START and STOP in the same cycle from HOLD -> stays HOLD; START with TICK in the same cycle from IDLE with COUNT=4 -> COUNT still 4 the next cycle.
REQ-039 Test: LOAD_VAL=7 with LOAD while in RUN at COUNT=1 with TICK high -> COUNT=7, IDLE, no EXPIRE, EXP_CNT=0.
REQ-040 Test: RESET in RUN with COUNT=1 and TICK high -> all outputs 0 next cycle; EXPIRE never asserted; START after a LOAD-free reset ignored (COUNT=0).
